// File: rtl/acc_seq_ctrl.sv
// Accumulator-buffer sequencer: drives K partial-sum passes into the accumulator write port
// for one output tile, then streams the saturated rows out of the read port under valid/ready.
module acc_seq_ctrl #(
  parameter int unsigned RAM_DEPTH = 64,
  parameter int unsigned KT_W      = 8,
  parameter int unsigned ROW_W     = 7,
  localparam int unsigned ADDR_W   = (RAM_DEPTH > 2) ? $clog2(RAM_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ROW_W-1:0]  cfg_rows,
  input  logic [KT_W-1:0]   cfg_kpass,
  input  logic              sa_valid,
  output logic              acc_wea,
  output logic              acc_en,
  output logic [ADDR_W-1:0] acc_addra,
  output logic              acc_enb,
  output logic [ADDR_W-1:0] acc_addrb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned SUM_W = ((ADDR_W > ROW_W) ? ADDR_W : ROW_W) + 1;

  typedef enum logic [1:0] {StIdle, StAcc, StRead, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ROW_W-1:0]    rows_q, rows_d;
  logic [KT_W-1:0]     kpass_q, kpass_d;
  logic [ROW_W-1:0]    row_cnt_q, row_cnt_d;
  logic [KT_W-1:0]     pass_cnt_q, pass_cnt_d;
  logic [ROW_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [ROW_W-1:0]    pres_cnt_q, pres_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic                err_q, err_d;

  logic wr, rd_issue, row_last, pass_last, pres_last;

  // Base is always below RAM_DEPTH and the offset never exceeds it, so one subtract wraps.
  function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] b,
                                                 input logic [ROW_W-1:0]  c);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(b) + SUM_W'(c);
    if (sum >= SUM_W'(RAM_DEPTH)) sum = sum - SUM_W'(RAM_DEPTH);
    return sum[ADDR_W-1:0];
  endfunction

  always_comb begin
    wr        = sa_valid && (state_q == StAcc);
    row_last  = (row_cnt_q == rows_q - ROW_W'(1));
    pass_last = (pass_cnt_q == kpass_q - KT_W'(1));
    pres_last = (pres_cnt_q == rows_q - ROW_W'(1));
    rd_issue  = (state_q == StRead) && (rd_cnt_q < rows_q) && (!out_valid_q || out_ready);

    state_d     = state_q;
    base_d      = base_q;
    rows_d      = rows_q;
    kpass_d     = kpass_q;
    row_cnt_d   = row_cnt_q;
    pass_cnt_d  = pass_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    pres_cnt_d  = pres_cnt_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d     = cfg_base;
          rows_d     = cfg_rows;
          kpass_d    = cfg_kpass;
          row_cnt_d  = '0;
          pass_cnt_d = '0;
          rd_cnt_d   = '0;
          pres_cnt_d = '0;
          err_d      = 1'b0;
          state_d    = (cfg_rows == '0 || cfg_kpass == '0) ? StDone : StAcc;
        end
      end
      StAcc: begin
        if (wr) begin
          if (row_last) begin
            row_cnt_d  = '0;
            pass_cnt_d = pass_cnt_q + KT_W'(1);
            if (pass_last) state_d = StRead;
          end else begin
            row_cnt_d = row_cnt_q + ROW_W'(1);
          end
        end
      end
      StRead: begin
        // doutb is held by the RAM while enb is low, so a stall just withholds the next issue.
        if (rd_issue) begin
          rd_cnt_d    = rd_cnt_q + ROW_W'(1);
          pres_cnt_d  = rd_cnt_q;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
        end
        if (out_valid_q && out_ready && pres_last) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (sa_valid && (state_q != StAcc)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      base_q      <= '0;
      rows_q      <= '0;
      kpass_q     <= '0;
      row_cnt_q   <= '0;
      pass_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      pres_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      rows_q      <= rows_d;
      kpass_q     <= kpass_d;
      row_cnt_q   <= row_cnt_d;
      pass_cnt_q  <= pass_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      pres_cnt_q  <= pres_cnt_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    acc_wea   = wr;
    acc_en    = (state_q == StAcc) && (pass_cnt_q != '0);
    acc_addra = (state_q == StAcc) ? wrap_add(base_q, row_cnt_q) : '0;
    acc_enb   = rd_issue;
    acc_addrb = (state_q == StRead) ? wrap_add(base_q, rd_cnt_q) : '0;
    out_valid = out_valid_q;
    out_last  = out_valid_q && pres_last;
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    err       = err_q;
  end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Bench for acc_seq_ctrl: a behavioural 4-lane int8 accumulator RAM sits on the ports, and
// expected write/read sequences come from per-tile arithmetic over the stimulus rows.
module tb_acc_seq_ctrl;
  localparam int DEPTH = 64;
  localparam int LANES = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  cfg_base = '0;
  logic [6:0]  cfg_rows = '0;
  logic [7:0]  cfg_kpass = '0;
  logic        sa_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] dina = '0;
  logic [31:0] doutb = '0;
  logic        acc_wea, acc_en, acc_enb, out_valid, out_last, busy, done, err;
  logic [5:0]  acc_addra, acc_addrb;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int enb_cnt = 0;

  int          acc_mem [DEPTH][LANES];
  logic [31:0] stim[$];
  int          wr_addr_log[$], rd_addr_log[$], hs_cyc_log[$], done_cyc_log[$];
  bit          wr_en_log[$], hs_last_log[$];
  logic [31:0] hs_data_log[$];
  int          exp_wr_addr[$], exp_rd_addr[$];
  bit          exp_wr_en[$];
  logic [31:0] exp_rd_data[$];

  acc_seq_ctrl #(.RAM_DEPTH(DEPTH), .KT_W(8), .ROW_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_base(cfg_base), .cfg_rows(cfg_rows),
    .cfg_kpass(cfg_kpass), .sa_valid(sa_valid), .acc_wea(acc_wea), .acc_en(acc_en),
    .acc_addra(acc_addra), .acc_enb(acc_enb), .acc_addrb(acc_addrb), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lane(input logic [31:0] d, input int l);
    logic [7:0] b;
    b = d[8*l +: 8];
    return int'($signed(b));
  endfunction

  function automatic logic [7:0] sat8(input int v);
    if (v > 127) return 8'h7f;
    if (v < -128) return 8'h80;
    return v[7:0];
  endfunction

  // Accumulator RAM: wide lanes, saturating int8 read port, 1-cycle latency, holds when enb=0.
  always @(posedge clk) begin
    if (acc_wea)
      for (int l = 0; l < LANES; l++)
        acc_mem[acc_addra][l] <= (acc_en ? acc_mem[acc_addra][l] : 0) + lane(dina, l);
    if (acc_enb)
      doutb <= {sat8(acc_mem[acc_addrb][3]), sat8(acc_mem[acc_addrb][2]),
                sat8(acc_mem[acc_addrb][1]), sat8(acc_mem[acc_addrb][0])};
  end

  always @(negedge clk) begin
    if (acc_wea) begin wr_addr_log.push_back(int'(acc_addra)); wr_en_log.push_back(acc_en); end
    if (acc_enb) begin rd_addr_log.push_back(int'(acc_addrb)); enb_cnt++; end
    if (out_valid && out_ready) begin
      hs_data_log.push_back(doutb);
      hs_last_log.push_back(out_last);
      hs_cyc_log.push_back(cyc);
    end
    if (done) done_cyc_log.push_back(cyc);
  end

  // Reference: pass p writes row r at (base+r)%DEPTH; row r reads out as sat(sum over passes).
  function automatic void build_ref(input int base, input int rows, input int kpass);
    logic [31:0] w;
    int s;
    exp_wr_addr.delete(); exp_wr_en.delete(); exp_rd_addr.delete(); exp_rd_data.delete();
    for (int p = 0; p < kpass; p++)
      for (int r = 0; r < rows; r++) begin
        exp_wr_addr.push_back((base + r) % DEPTH);
        exp_wr_en.push_back(p != 0);
      end
    if (kpass == 0) return;
    for (int r = 0; r < rows; r++) begin
      exp_rd_addr.push_back((base + r) % DEPTH);
      for (int l = 0; l < LANES; l++) begin
        s = 0;
        for (int p = 0; p < kpass; p++) s += lane(stim[p*rows + r], l);
        w[8*l +: 8] = sat8(s);
      end
      exp_rd_data.push_back(w);
    end
  endfunction

  task automatic idle_cycle(input int rmode);
    sa_valid = 1'b0;
    out_ready = (rmode != 0) ? 1'($urandom_range(1)) : 1'b1;
    @(posedge clk); #1;
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic start_and_fill(input int base, input int rows, input int kpass, input int gap,
                                input int rmode, input int restart_at);
    wr_addr_log.delete(); wr_en_log.delete(); rd_addr_log.delete(); hs_data_log.delete();
    hs_last_log.delete(); hs_cyc_log.delete(); done_cyc_log.delete(); enb_cnt = 0;
    cfg_base = base[5:0]; cfg_rows = rows[6:0]; cfg_kpass = kpass[7:0];
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < rows * kpass; i++) begin
      while ($urandom_range(99) < gap) idle_cycle(rmode);
      if (i == restart_at) begin
        cfg_base = 6'd40; cfg_rows = 7'd7; cfg_kpass = 8'd2; start = 1'b1;
        idle_cycle(rmode);
        start = 1'b0;
      end
      sa_valid = 1'b1;
      dina = stim[i];
      out_ready = (rmode != 0) ? 1'($urandom_range(1)) : 1'b1;
      @(posedge clk); #1;
    end
    sa_valid = 1'b0;
    dina = '0;
  endtask

  task automatic drain(input int rmode, output bit to);
    to = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      if (done_cyc_log.size() != 0) begin to = 1'b0; break; end
      out_ready = (rmode != 0) ? 1'($urandom_range(1)) : 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    total++;
    if ({acc_wea, acc_en, acc_enb, out_valid, out_last, busy, done, err, acc_addra, acc_addrb}
        !== 20'd0) begin
      bad++;
      $display("FAIL reset_outputs got wea=%b en=%b enb=%b ov=%b last=%b busy=%b done=%b err=%b a=%0d b=%0d want all 0",
               acc_wea, acc_en, acc_enb, out_valid, out_last, busy, done, err, acc_addra, acc_addrb);
    end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL reset_idle got busy=%b done=%b err=%b want 0 0 0", busy, done, err);
    end
  endtask

  task automatic test_basic;
    bit to;
    stim.delete();
    for (int i = 0; i < 12; i++) stim.push_back(32'h05050505);
    build_ref(0, 4, 3);
    start_and_fill(0, 4, 3, 0, 0, -1);
    drain(0, to);
    total++;
    if (to || wr_addr_log.size() != 12 || hs_data_log.size() != 4) begin
      bad++;
      $display("FAIL basic_counts got wr=%0d rd=%0d to=%0b want wr=12 rd=4 to=0",
               wr_addr_log.size(), hs_data_log.size(), to);
    end else begin
      for (int i = 0; i < 12; i++) begin
        total++;
        if (wr_addr_log[i] !== i % 4 || wr_en_log[i] !== (i >= 4)) begin
          bad++;
          $display("FAIL basic_write[%0d] got addr=%0d en=%b want addr=%0d en=%b",
                   i, wr_addr_log[i], wr_en_log[i], i % 4, i >= 4);
        end
      end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (hs_data_log[i] !== 32'h0f0f0f0f || hs_last_log[i] !== (i == 3)) begin
          bad++;
          $display("FAIL basic_read[%0d] got data=%h last=%b want data=0f0f0f0f last=%b",
                   i, hs_data_log[i], hs_last_log[i], i == 3);
        end
      end
      total++;
      if (done_cyc_log[0] !== hs_cyc_log[3] + 1 || hs_cyc_log[3] - hs_cyc_log[0] !== 3
          || enb_cnt !== 4) begin
        bad++;
        $display("FAIL basic_timing got done=%0d hs0=%0d hs3=%0d enb=%0d want done=hs3+1 span=3 enb=4",
                 done_cyc_log[0], hs_cyc_log[0], hs_cyc_log[3], enb_cnt);
      end
    end
  endtask

  task automatic test_wrap;
    bit to;
    stim.delete();
    for (int i = 0; i < 4; i++) stim.push_back($urandom);
    build_ref(62, 4, 1);
    start_and_fill(62, 4, 1, 30, 1, -1);
    drain(1, to);
    total++;
    if (to || wr_addr_log.size() != 4 || rd_addr_log.size() != 4 || hs_data_log.size() != 4) begin
      bad++;
      $display("FAIL wrap_counts got wr=%0d rda=%0d rd=%0d to=%0b want 4 4 4 0",
               wr_addr_log.size(), rd_addr_log.size(), hs_data_log.size(), to);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (wr_addr_log[i] !== exp_wr_addr[i] || rd_addr_log[i] !== exp_rd_addr[i]
            || hs_data_log[i] !== exp_rd_data[i] || hs_last_log[i] !== (i == 3)) begin
          bad++;
          $display("FAIL wrap_row[%0d] got a=%0d b=%0d d=%h last=%b want a=%0d b=%0d d=%h last=%b",
                   i, wr_addr_log[i], rd_addr_log[i], hs_data_log[i], hs_last_log[i],
                   exp_wr_addr[i], exp_rd_addr[i], exp_rd_data[i], i == 3);
        end
      end
    end
  endtask

  task automatic test_saturation;
    bit to;
    logic [31:0] in_w, want;
    for (int t = 0; t < 2; t++) begin
      in_w = (t == 0) ? 32'h64646464 : 32'h9c9c9c9c;
      want = (t == 0) ? 32'h7f7f7f7f : 32'h80808080;
      stim.delete();
      for (int i = 0; i < 4; i++) stim.push_back(in_w);
      start_and_fill(10, 2, 2, 0, 0, -1);
      drain(0, to);
      total++;
      if (to || hs_data_log.size() != 2) begin
        bad++; $display("FAIL sat%0d_count got rd=%0d to=%0b want rd=2 to=0", t, hs_data_log.size(), to);
      end else begin
        for (int i = 0; i < 2; i++) begin
          total++;
          if (hs_data_log[i] !== want) begin
            bad++; $display("FAIL sat%0d_row[%0d] got %h want %h", t, i, hs_data_log[i], want);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure;
    bit to;
    stim.delete();
    for (int i = 0; i < 4; i++) stim.push_back($urandom);
    build_ref(5, 4, 1);
    start_and_fill(5, 4, 1, 0, 0, -1);
    to = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (done_cyc_log.size() != 0) begin to = 1'b0; break; end
      out_ready = !(k >= 2 && k <= 4);
      if (k >= 2 && k <= 4) begin
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || doutb !== exp_rd_data[0] || acc_enb !== 1'b0) begin
          bad++;
          $display("FAIL bp_stall_k%0d got ov=%b d=%h enb=%b want ov=1 d=%h enb=0",
                   k, out_valid, doutb, acc_enb, exp_rd_data[0]);
        end
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    total++;
    if (to || hs_data_log.size() != 4 || enb_cnt != 4) begin
      bad++;
      $display("FAIL bp_counts got rd=%0d enb=%0d to=%0b want rd=4 enb=4 to=0",
               hs_data_log.size(), enb_cnt, to);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (hs_data_log[i] !== exp_rd_data[i] || hs_last_log[i] !== (i == 3)) begin
          bad++;
          $display("FAIL bp_row[%0d] got d=%h last=%b want d=%h last=%b",
                   i, hs_data_log[i], hs_last_log[i], exp_rd_data[i], i == 3);
        end
      end
      total++;
      if (hs_cyc_log[3] - hs_cyc_log[0] !== 3) begin
        bad++; $display("FAIL bp_throughput got span=%0d want 3", hs_cyc_log[3] - hs_cyc_log[0]);
      end
    end
  endtask

  task automatic test_degenerate;
    bit to;
    for (int t = 0; t < 2; t++) begin
      stim.delete();
      start_and_fill(9, (t == 0) ? 0 : 5, (t == 0) ? 3 : 0, 0, 0, -1);
      drain(0, to);
      total++;
      if (to || done_cyc_log[0] !== start_cyc + 1 || wr_addr_log.size() != 0 || enb_cnt != 0) begin
        bad++;
        $display("FAIL degen%0d got to=%0b done_at=+%0d wr=%0d enb=%0d want to=0 done_at=+1 wr=0 enb=0",
                 t, to, (done_cyc_log.size() != 0) ? done_cyc_log[0] - start_cyc : -1,
                 wr_addr_log.size(), enb_cnt);
      end
    end
    // A start pulse in the middle of ACC must not disturb the running tile.
    stim.delete();
    for (int i = 0; i < 2; i++) stim.push_back($urandom);
    build_ref(20, 2, 1);
    start_and_fill(20, 2, 1, 0, 0, 1);
    drain(0, to);
    total++;
    if (to || wr_addr_log.size() != 2 || hs_data_log.size() != 2) begin
      bad++;
      $display("FAIL restart_counts got wr=%0d rd=%0d to=%0b want 2 2 0",
               wr_addr_log.size(), hs_data_log.size(), to);
    end else begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (wr_addr_log[i] !== exp_wr_addr[i] || hs_data_log[i] !== exp_rd_data[i]) begin
          bad++;
          $display("FAIL restart_row[%0d] got a=%0d d=%h want a=%0d d=%h",
                   i, wr_addr_log[i], hs_data_log[i], exp_wr_addr[i], exp_rd_data[i]);
        end
      end
    end
    // Stray sa_valid while idle: no write, sticky err until the next accepted start.
    sa_valid = 1'b1;
    @(negedge clk);
    total++;
    if (acc_wea !== 1'b0) begin bad++; $display("FAIL idle_sa_wea got %b want 0", acc_wea); end
    @(posedge clk); #1;
    sa_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL idle_sa_err got err=%b busy=%b want err=1 busy=0", err, busy);
    end
    stim.delete();
    stim.push_back($urandom);
    start_and_fill(33, 1, 1, 0, 0, -1);
    drain(0, to);
    total++;
    if (to || err !== 1'b0) begin
      bad++; $display("FAIL err_clear got err=%b to=%0b want err=0 to=0", err, to);
    end
  endtask

  task automatic test_reset_mid;
    bit to;
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back($urandom);
    start_and_fill(3, 8, 2, 0, 0, -1); // fill stops early below via reset
  endtask

  task automatic test_reset_mid_acc;
    bit to;
    cfg_base = 6'd3; cfg_rows = 7'd8; cfg_kpass = 8'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sa_valid = 1'b1; dina = $urandom;
      @(posedge clk); #1;
    end
    total++;
    if (busy !== 1'b1 || acc_wea !== 1'b1) begin
      bad++; $display("FAIL mid_acc_pre got busy=%b wea=%b want 1 1", busy, acc_wea);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({acc_wea, acc_en, acc_enb, out_valid, out_last, busy, done, err, acc_addra, acc_addrb}
        !== 20'd0) begin
      bad++;
      $display("FAIL mid_reset_outputs got wea=%b en=%b enb=%b ov=%b busy=%b err=%b a=%0d want all 0",
               acc_wea, acc_en, acc_enb, out_valid, busy, err, acc_addra);
    end
    sa_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    stim.delete();
    for (int i = 0; i < 2; i++) stim.push_back($urandom);
    build_ref(30, 2, 1);
    start_and_fill(30, 2, 1, 0, 0, -1);
    drain(0, to);
    total++;
    if (to || wr_addr_log.size() != 2 || hs_data_log.size() != 2) begin
      bad++;
      $display("FAIL post_reset_counts got wr=%0d rd=%0d to=%0b want 2 2 0",
               wr_addr_log.size(), hs_data_log.size(), to);
    end else begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (wr_addr_log[i] !== exp_wr_addr[i] || wr_en_log[i] !== 1'b0
            || hs_data_log[i] !== exp_rd_data[i] || hs_last_log[i] !== (i == 1)) begin
          bad++;
          $display("FAIL post_reset_row[%0d] got a=%0d en=%b d=%h last=%b want a=%0d en=0 d=%h last=%b",
                   i, wr_addr_log[i], wr_en_log[i], hs_data_log[i], hs_last_log[i],
                   exp_wr_addr[i], exp_rd_data[i], i == 1);
        end
      end
    end
  endtask

  task automatic test_random;
    bit to;
    int base, rows, kpass;
    for (int t = 0; t < 7; t++) begin
      base  = $urandom_range(DEPTH - 1);
      rows  = (t == 6) ? DEPTH : $urandom_range(10, 1);
      kpass = (t == 6) ? 1 : $urandom_range(4, 1);
      stim.delete();
      for (int i = 0; i < rows * kpass; i++) stim.push_back($urandom);
      build_ref(base, rows, kpass);
      start_and_fill(base, rows, kpass, 40, 1, -1);
      drain(1, to);
      total++;
      if (to || wr_addr_log.size() != exp_wr_addr.size() || rd_addr_log.size() != rows
          || hs_data_log.size() != rows) begin
        bad++;
        $display("FAIL rand%0d_counts got wr=%0d rda=%0d rd=%0d to=%0b want wr=%0d rd=%0d to=0",
                 t, wr_addr_log.size(), rd_addr_log.size(), hs_data_log.size(), to,
                 exp_wr_addr.size(), rows);
      end else begin
        for (int i = 0; i < exp_wr_addr.size(); i++) begin
          total++;
          if (wr_addr_log[i] !== exp_wr_addr[i] || wr_en_log[i] !== exp_wr_en[i]) begin
            bad++;
            $display("FAIL rand%0d_write[%0d] got a=%0d en=%b want a=%0d en=%b",
                     t, i, wr_addr_log[i], wr_en_log[i], exp_wr_addr[i], exp_wr_en[i]);
          end
        end
        for (int i = 0; i < rows; i++) begin
          total++;
          if (rd_addr_log[i] !== exp_rd_addr[i] || hs_data_log[i] !== exp_rd_data[i]
              || hs_last_log[i] !== (i == rows - 1)) begin
            bad++;
            $display("FAIL rand%0d_read[%0d] got b=%0d d=%h last=%b want b=%0d d=%h last=%b",
                     t, i, rd_addr_log[i], hs_data_log[i], hs_last_log[i],
                     exp_rd_addr[i], exp_rd_data[i], i == rows - 1);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_saturation;
    test_backpressure;
    test_degenerate;
    test_reset_mid_acc;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acc_seq_ctrl.md
Name: acc_seq_ctrl

Overview:
- Sequencer for the accumulator buffer that sits between the systolic array output and the unified buffer write-back path.
- For one output tile, it drives the accumulator write port across K partial-sum passes: the first pass overwrites and later passes accumulate.
- It then streams the saturated rows out of the read port under a valid/ready handshake.
- Configuration is latched at start; the top-level controller observes busy/done.

Parameters:
- RAM_DEPTH, 64, accumulator entries; ADDR_W = clogb2(RAM_DEPTH-1).
- KT_W, 8, width of the K-pass count.
- ROW_W, 7, width of the row count; must hold RAM_DEPTH.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- cfg_base  in  ADDR_W  first accumulator row of the tile.
- cfg_rows  in  ROW_W  rows per pass, 0..RAM_DEPTH.
- cfg_kpass  in  KT_W  number of partial-sum passes.
- sa_valid  in  1  systolic array presents one result row (data goes straight to the accumulator dina).
- acc_wea  out  1  accumulator write enable.
- acc_en  out  1  accumulator accumulate select.
- acc_addra  out  ADDR_W  accumulator write address.
- acc_enb  out  1  accumulator read enable.
- acc_addrb  out  ADDR_W  accumulator read address.
- out_valid  out  1  accumulator doutb holds a valid row.
- out_ready  in  1  downstream accepts the row.
- out_last  out  1  qualifies the final row of the tile.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at tile completion.
- err  out  1  sticky: sa_valid seen outside ACC; cleared by the next accepted start.

Behaviour:
- Reset: state=IDLE and all counters are 0. acc_wea, acc_en, acc_enb, out_valid, out_last, busy, done and err are 0; the address outputs are 0.
- States:
  - IDLE --start--> ACC, or --start--> DONE if cfg_rows==0 or cfg_kpass==0.
  - ACC --(last row of last pass written)--> READ.
  - READ --(last row accepted)--> DONE.
  - DONE --> IDLE unconditionally.
- At start: latch cfg_base/cfg_rows/cfg_kpass; clear row_cnt, pass_cnt and err.
- ACC write path (combinational, same cycle as sa_valid):
  - acc_wea = sa_valid & (state==ACC).
  - acc_addra = (base + row_cnt) mod RAM_DEPTH; wraps past RAM_DEPTH-1 to 0.
  - acc_en = (pass_cnt != 0), so the first pass overwrites and later passes add.
  - On each write, row_cnt increments. At row_cnt==rows-1, row_cnt returns to 0 and pass_cnt increments. A write with pass_cnt==kpass-1 and row_cnt==rows-1 moves the FSM to READ.
- READ path:
  - The read address walks (base + rd_cnt) mod RAM_DEPTH.
  - acc_enb = (state==READ) & (rd_cnt < rows) & (!out_valid | out_ready).
  - Read latency is 1 cycle: out_valid is set on the cycle after acc_enb.
  - If a row is accepted with no new issue, out_valid clears.
  - The accumulator holds doutb while acc_enb=0, so no skid buffer is needed.
  - Full throughput of 1 row/cycle is required when out_ready stays high.
  - out_last = out_valid & (row being presented is number rows-1).
  - Exit to DONE on the cycle the last row handshakes (out_valid & out_ready & out_last).
- DONE: done=1 for exactly one cycle, busy remains 1; next state IDLE.
- Boundary rules:
  - start outside IDLE is ignored.
  - sa_valid outside ACC produces no write and sets err.
  - cfg_rows==RAM_DEPTH covers every entry exactly once.
  - out_valid never drops without a handshake.
  - Async reset mid-tile returns to IDLE immediately with outputs at reset values; accumulator contents are unspecified.

Test Plan:
- Basic tile, base=0, rows=4, kpass=3, sa_valid every cycle: expect 12 writes at addra 0,1,2,3 ×3, with acc_en=0 on the first 4 and 1 on the remaining 8. With inputs all 5, the readout stream is 15,15,15,15 with out_last on the 4th and done one cycle after the 4th handshake.
- Wrap-around, base=62, rows=4, kpass=1: addra is 62,63,0,1 and addrb is 62,63,0,1.
- Saturation, two passes of +100: readout is 127 (max) per lane; two passes of -100 give -128.
- Backpressure, rows=4, out_ready low on cycles 2-4 of READ: out_valid and the data stay stable, no acc_enb is issued while stalled, all 4 rows arrive in order exactly once, and throughput is 1/cycle when out_ready=1.
- Degenerate config, rows=0: start gives done one cycle later with no wea/enb. A second start during ACC is ignored, and sa_valid in IDLE sets err with no write.
- rst_n asserted mid-ACC (after 5 writes): all outputs drop to 0 asynchronously and state is IDLE. A following start with rows=2, kpass=1 completes normally.
